nbit_shift_restore: RTL

- Sequential inverse of the n-bit shifter: takes a shifted result, its overflow (shifted-out) bits and the original shift control word, and rebuilds the original operand.
- Restores one bit per clock in the direction opposite to the original shift.
- Sits downstream of the shifter in the ALU datapath for self-check and undo of shift operations, with valid/ready handshakes on both sides.

---
 rtl/nbit_shift_restore_if.sv | 28 ++
 rtl/nbit_shift_restore.sv | 123 ++++++++++++
 2 files changed

// File: rtl/nbit_shift_restore_if.sv
// Request/response bundle for nbit_shift_restore: a shifted word plus its
// shifted-out bits and control word in, the rebuilt operand out.
interface nbit_shift_restore_if #(
    parameter int WIDTH = 4
);
    // A transfer happens on a rising edge where valid and ready are both high;
    // the sender holds its payload stable from raising valid until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] overflow;
    logic [WIDTH-1:0] shift;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] restored;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, shifted, overflow, shift, out_ready,
        input  in_ready, out_valid, restored, err, busy
    );

    modport slave (
        input  in_valid, shifted, overflow, shift, out_ready,
        output in_ready, out_valid, restored, err, busy
    );
endinterface

// File: rtl/nbit_shift_restore.sv
// Undoes an n-bit shift one bit per clock, feeding the shifted-out bits back in
// from the side they left through.
module nbit_shift_restore #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    nbit_shift_restore_if.slave bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int KW = WIDTH - 2;
    localparam int XW = KW + CW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0] restored_q, restored_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [CW-1:0]    k_q, k_d;
    logic [CW-1:0]    step_q, step_d;

    logic [XW-1:0]    k_ext;
    logic             k_err;
    logic             k_zero;
    logic [CW-1:0]    ovf_idx;
    logic             ovf_bit;
    logic [WIDTH-1:0] data_step;
    logic             last_step;
    logic             unused_fill;

    assign unused_fill = bus.shift[WIDTH-1];
    assign k_ext       = XW'(bus.shift[WIDTH-2:1]);
    assign k_err       = (k_ext >= XW'(WIDTH));
    assign k_zero      = (k_ext == '0);

    // Left shifts lost their top bits, so they re-enter at the MSB lowest-first;
    // right shifts lost their bottom bits, which re-enter at the LSB highest-first.
    assign ovf_idx   = dir_q ? (k_q - step_q - CW'(1)) : step_q;
    assign ovf_bit   = |(ovf_q & (WIDTH'(1) << ovf_idx));
    assign data_step = dir_q ? {data_q[WIDTH-2:0], ovf_bit}
                             : {ovf_bit, data_q[WIDTH-1:1]};
    assign last_step = (step_q == k_q - CW'(1));

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        restored_d = restored_q;
        dir_d      = dir_q;
        err_d      = err_q;
        k_d        = k_q;
        step_d     = step_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d = bus.shifted;
                    ovf_d  = bus.overflow;
                    dir_d  = bus.shift[0];
                    k_d    = k_ext[CW-1:0];
                    step_d = '0;
                    err_d  = k_err;
                    if (k_err || k_zero) begin
                        restored_d = bus.shifted;
                        state_d    = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                data_d = data_step;
                step_d = step_q + CW'(1);
                if (last_step) begin
                    restored_d = data_step;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            ovf_q      <= '0;
            restored_q <= '0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            k_q        <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            restored_q <= restored_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            k_q        <= k_d;
            step_q     <= step_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.restored  = restored_q;
    assign bus.err       = err_q;
    assign dbg_state     = state_q;
endmodule
